mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single byte-wide RAM port between the instruction-fetch stage (word reads at the PC) and the load/store stage (byte, half and word reads and writes).
- Serialises each request into byte accesses, assembles little-endian results and returns a one-cycle done pulse per requester.
- Sits between the pipeline front/back ends and the top-level RAM bus.
- All pipeline memory traffic goes through this block.

Parameters:
ADDR_W, 32, address width of requests and of mem_a
RD_LAT, 2, clock edges from the edge that registers mem_a to the edge at which mem_din carries that byte (valid values 1 and 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (rst==0 resets on rising clk edge)
rdy  input  1  global run enable; 0 = freeze all state
if_req  input  1  fetch request, level, held until if_done
if_addr  input  ADDR_W  fetch byte address
if_done  output  1  one-cycle pulse, fetch complete
if_inst  output  32  fetched word, valid while if_done=1
ls_req  input  1  load/store request, level, held until ls_done
ls_we  input  1  1 = store, 0 = load
ls_size  input  2  0=byte, 1=half, 2=word; 3 is treated as word
ls_addr  input  ADDR_W  load/store byte address
ls_wdata  input  32  store data; low bytes used for byte/half
ls_done  output  1  one-cycle pulse, load/store complete
ls_rdata  output  32  load data, zero-extended, valid while ls_done=1
mem_a  output  ADDR_W  RAM byte address (registered)
mem_dout  output  8  RAM write byte (registered)
mem_wr  output  1  RAM write strobe (registered)
mem_din  input  8  RAM read byte

Behaviour:
- Reset (rst==0 at an edge, overrides rdy):
  - state=IDLE, byte counters=0.
  - All outputs 0: mem_a, mem_dout, mem_wr, if_done, ls_done, if_inst, ls_rdata.
  - Reset mid-transaction aborts it, with no done pulse; mem_wr must be 0 from the next cycle.
- rdy==0: no register updates, outputs hold. rdy is checked after reset.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Fixed priority, ls before if: if ls_req, grant ls; else if if_req, grant if.
  - On grant, latch addr, N (1/2/4 bytes; fetch is always 4), we and wdata.
  - Read grant: mem_a<=addr, mem_wr<=0, go to READ.
  - Write grant: mem_a<=addr, mem_dout<=wdata[7:0], mem_wr<=1, go to WRITE.
- READ:
  - Issue addresses addr+1 .. addr+N-1 on consecutive edges.
  - Capture mem_din into byte k of the buffer at edge (issue_k + RD_LAT); byte 0 is bits 7:0.
  - At the edge capturing byte N-1: drive result to the granted requester's data output, upper bytes 0, pulse its done<=1, go to DONE.
  - Word read (RD_LAT=2): grant edge E0, bytes captured E2..E5, done high in the cycle after E5. Read latency is N+RD_LAT-1 edges after grant.
- WRITE:
  - Edge k (k=1..N-1): mem_a<=addr+k, mem_dout<=wdata byte k, mem_wr stays 1.
  - Edge N: mem_wr<=0, ls_done<=1, go to DONE. Write latency is N edges.
  - Stores come only from ls; if_req never produces a write.
- DONE: requests are ignored for this one cycle, letting requesters drop req. Next edge: done<=0, go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W; 0xFFFFFFFF+1 gives 0.
- mem_a is don't-care when idle but must not glitch mem_wr.
- if_inst and ls_rdata hold their last values after done.
- A requester that changes addr/size/data mid-transaction has no effect; values were latched at grant.
- If both requests are pending, ls is served first; fetch waits in IDLE arbitration until ls completes.

Optional Feature:
MEM_ARB_ROUNDROBIN_EN
- Defined: a last-grant flag (reset value = if) makes simultaneous requests alternate; the requester not granted last wins. A lone request is granted immediately.
- Undefined: fixed ls-over-if priority as above; no last-grant flag exists.

Test Plan:
1. Reset, then if_req=1 at if_addr=0x00000010 with RAM bytes 0x13,0x05,0x10,0x00 at 0x10..0x13 -> if_done one cycle, if_inst=0x00100513, exactly 5 cycles after the grant edge (RD_LAT=2).
2. ls store word 0xDEADBEEF at 0x100 -> mem_wr=1 for 4 cycles, mem_a 0x100..0x103, mem_dout EF,BE,AD,DE; ls_done 4 edges after grant; a readback load of 0x100 (size 2) -> ls_rdata=0xDEADBEEF.
3. ls load byte at 0x101 holding 0xBE -> ls_rdata=0x000000BE; ls load half at 0x102 -> 0x0000DEAD.
4. if_req and ls_req asserted in the same cycle -> ls served first, if_done follows after ls_done plus the DONE cycle. With MEM_ARB_ROUNDROBIN_EN and a repeated collision -> grants alternate.
5. rdy=0 for 3 cycles mid word-read -> all outputs frozen; completes with correct data, latency +3. rst=0 mid-store after 2 bytes -> mem_wr=0 the next cycle, no ls_done, state IDLE.
6. Fetch at 0xFFFFFFFE -> mem_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and load/store.
// Each request becomes a run of byte accesses. Read bytes are assembled little-endian.
// Each requester gets a one-cycle done pulse when its request completes.
//
// Parameters:
//   ADDR_W  address width of requests and mem_a
//   RD_LAT  edges from registering mem_a to sampling that byte on mem_din (1 or 2)
//
// Ports:
//   clk, rst (sync, active-low), rdy (0 freezes all state)
//   if_req/if_addr -> if_done/if_inst   fetch side, always a 4-byte read
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata -> ls_done/ls_rdata   load/store side
//   mem_a/mem_dout/mem_wr (registered), mem_din   byte RAM bus
//
// Optional feature macro: MEM_ARB_ROUNDROBIN_EN
//   Defined:   simultaneous requests alternate, starting from ls.
//   Undefined: fixed ls-over-if priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  localparam logic [3:0] Lat = 4'(RD_LAT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              sel_ls_q, sel_ls_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic              grant_ls, grant_if;
  logic [3:0]        step;      // index of the current edge counted from the grant edge
  logic [3:0]        nb4;
  logic [1:0]        cap_idx;
  logic [1:0]        wr_idx;
  logic [2:0]        ls_nbytes;

`ifdef MEM_ARB_ROUNDROBIN_EN
  // 1 when ls received the most recent grant; reset value favours ls on the first collision.
  logic last_ls_q, last_ls_d;

  assign grant_ls = ls_req & (~if_req | ~last_ls_q);

  always_comb begin
    last_ls_d = last_ls_q;
    if (state_q == StIdle && (ls_req || if_req)) begin
      last_ls_d = grant_ls;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_ls_q <= 1'b0;
    end else if (rdy) begin
      last_ls_q <= last_ls_d;
    end
  end
`else
  assign grant_ls = ls_req;
`endif

  assign grant_if = if_req & ~grant_ls;

  always_comb begin
    unique case (ls_size)
      2'd0:    ls_nbytes = 3'd1;
      2'd1:    ls_nbytes = 3'd2;
      default: ls_nbytes = 3'd4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    nbytes_d   = nbytes_q;
    wdata_d    = wdata_q;
    sel_ls_d   = sel_ls_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_inst_d  = if_inst_q;
    ls_rdata_d = ls_rdata_q;

    step    = cnt_q + 4'd1;
    nb4     = {1'b0, nbytes_q};
    cap_idx = 2'(step - Lat);
    wr_idx  = step[1:0];

    unique case (state_q)
      StIdle: begin
        cnt_d = 4'd0;
        buf_d = 32'd0;
        if (grant_ls) begin
          addr_d   = ls_addr;
          nbytes_d = ls_nbytes;
          wdata_d  = ls_wdata;
          sel_ls_d = 1'b1;
          mem_a_d  = ls_addr;
          if (ls_we) begin
            mem_dout_d = ls_wdata[7:0];
            mem_wr_d   = 1'b1;
            state_d    = StWrite;
          end else begin
            mem_wr_d = 1'b0;
            state_d  = StRead;
          end
        end else if (grant_if) begin
          addr_d   = if_addr;
          nbytes_d = 3'd4;
          wdata_d  = 32'd0;
          sel_ls_d = 1'b0;
          mem_a_d  = if_addr;
          mem_wr_d = 1'b0;
          state_d  = StRead;
        end
      end

      StRead: begin
        cnt_d = step;
        if (step < nb4) begin
          mem_a_d = addr_q + ADDR_W'(step);
        end
        // Address issue and data capture overlap; capture trails issue by RD_LAT edges.
        if (step >= Lat) begin
          buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
          if (step == nb4 - 4'd1 + Lat) begin
            if (sel_ls_q) begin
              ls_rdata_d = buf_d;
              ls_done_d  = 1'b1;
            end else begin
              if_inst_d = buf_d;
              if_done_d = 1'b1;
            end
            state_d = StDone;
          end
        end
      end

      StWrite: begin
        cnt_d = step;
        if (step < nb4) begin
          mem_a_d    = addr_q + ADDR_W'(step);
          mem_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
        end else begin
          mem_wr_d  = 1'b0;
          ls_done_d = 1'b1;
          state_d   = StDone;
        end
      end

      StDone: begin
        // One dead cycle so requesters can drop req before arbitration resumes.
        cnt_d   = 4'd0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      nbytes_q   <= 3'd0;
      wdata_q    <= 32'd0;
      sel_ls_q   <= 1'b0;
      cnt_q      <= 4'd0;
      buf_q      <= 32'd0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_inst_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      nbytes_q   <= nbytes_d;
      wdata_q    <= wdata_d;
      sel_ls_q   <= sel_ls_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_inst_q  <= if_inst_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_inst  = if_inst_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (RD_LAT = 2).
// The RAM model is a 1 KiB byte array aliased on mem_a[9:0], with one read register.
// It stalls together with the arbiter when rdy is 0.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RD_LAT = 2;

`ifdef MEM_ARB_ROUNDROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, rdy;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              ls_req, ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_done (if_done),
    .if_inst (if_inst),
    .ls_req  (ls_req),
    .ls_we   (ls_we),
    .ls_size (ls_size),
    .ls_addr (ls_addr),
    .ls_wdata(ls_wdata),
    .ls_done (ls_done),
    .ls_rdata(ls_rdata),
    .mem_a   (mem_a),
    .mem_dout(mem_dout),
    .mem_wr  (mem_wr),
    .mem_din (mem_din)
  );

  // RAM model: single writer process for clear, preload and bus writes.
  logic [7:0] ram [0:1023];
  logic       ram_clr, pre_we;
  logic [9:0] pre_a;
  logic [7:0] pre_d;
  logic [7:0] rd_q;

  assign mem_din = rd_q;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    end else if (pre_we) begin
      ram[pre_a] <= pre_d;
    end else if (rdy && mem_wr) begin
      ram[mem_a[9:0]] <= mem_dout;
    end
    if (rdy) rd_q <= ram[mem_a[9:0]];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    tick;
    pre_we = 1'b0;
  endtask

  // Runs one ls request; lat = edges from the grant edge until ls_done is observed.
  task automatic ls_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int t;
    bit seen;
    ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wd; ls_req = 1'b1;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 40) begin
      tick;
      t++;
      if (ls_done) seen = 1'b1;
    end
    ls_req = 1'b0;
    check("ls_op_done_seen", 32'(seen), 32'd1);
    rd  = ls_rdata;
    lat = seen ? t - 1 : -1;
    tick;
  endtask

  task automatic fetch_op(input logic [31:0] addr, output logic [31:0] inst, output int lat);
    int t;
    bit seen;
    if_addr = addr; if_req = 1'b1;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 40) begin
      tick;
      t++;
      if (if_done) seen = 1'b1;
    end
    if_req = 1'b0;
    check("fetch_done_seen", 32'(seen), 32'd1);
    inst = if_inst;
    lat  = seen ? t - 1 : -1;
    tick;
  endtask

  // Both requesters assert together; each drops its request when its done pulse is seen.
  task automatic collide(input string tag, output bit ls_first);
    int t_ls, t_if, gap;
    t_ls = -1;
    t_if = -1;
    ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h100; if_addr = 32'h10;
    ls_req = 1'b1; if_req = 1'b1;
    for (int t = 1; t <= 60 && (t_ls < 0 || t_if < 0); t++) begin
      tick;
      if (ls_done) begin
        t_ls = t;
        ls_req = 1'b0;
        check({tag, "_ls_data"}, ls_rdata, 32'hDEADBEEF);
      end
      if (if_done) begin
        t_if = t;
        if_req = 1'b0;
        check({tag, "_if_data"}, if_inst, 32'h00100513);
      end
    end
    ls_req = 1'b0;
    if_req = 1'b0;
    check({tag, "_both_done"}, 32'((t_ls > 0) && (t_if > 0)), 32'd1);
    ls_first = (t_ls < t_if);
    gap = ls_first ? t_if - t_ls : t_ls - t_if;
    // DONE cycle + grant edge + 5-edge word read
    check({tag, "_gap"}, 32'(gap), 32'd7);
    tick;
  endtask

  logic [31:0] rd, exp_a [4], exp_d [4];
  int          lat;
  bit          ls_first;

  initial begin
    rst = 1'b0; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    ram_clr = 1'b1;
    tick;
    ram_clr = 1'b0;
    preload(10'h010, 8'h13);
    preload(10'h011, 8'h05);
    preload(10'h012, 8'h10);
    preload(10'h013, 8'h00);
    preload(10'h3FE, 8'h11);
    preload(10'h3FF, 8'h22);
    preload(10'h000, 8'h33);
    preload(10'h001, 8'h44);
    tick;

    // Reset state
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_ls_done", 32'(ls_done), 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    rst = 1'b1;

    // Fetch word at 0x10, done exactly 5 edges after grant
    if_addr = 32'h10; if_req = 1'b1;
    tick;
    check("f1_mem_a0", mem_a, 32'h10);
    check("f1_mem_wr", 32'(mem_wr), 32'd0);
    repeat (4) tick;
    check("f1_not_done_e4", 32'(if_done), 32'd0);
    tick;
    check("f1_done_e5", 32'(if_done), 32'd1);
    check("f1_inst", if_inst, 32'h00100513);
    if_req = 1'b0;
    tick;
    check("f1_done_pulse", 32'(if_done), 32'd0);
    check("f1_inst_hold", if_inst, 32'h00100513);

    // Store word 0xDEADBEEF at 0x100
    exp_a = '{32'h100, 32'h101, 32'h102, 32'h103};
    exp_d = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
    ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF; ls_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("st_mem_wr", 32'(mem_wr), 32'd1);
      check("st_mem_a", mem_a, exp_a[k]);
      check("st_mem_dout", 32'(mem_dout), exp_d[k]);
      check("st_no_done", 32'(ls_done), 32'd0);
    end
    tick;
    check("st_wr_off", 32'(mem_wr), 32'd0);
    check("st_done", 32'(ls_done), 32'd1);
    ls_req = 1'b0;
    tick;
    check("st_done_pulse", 32'(ls_done), 32'd0);

    ls_op(1'b0, 2'd2, 32'h100, 32'h0, rd, lat);
    check("ld_word_data", rd, 32'hDEADBEEF);
    check("ld_word_lat", 32'(lat), 32'd5);

    // Byte / half / size-3 loads
    ls_op(1'b0, 2'd0, 32'h101, 32'h0, rd, lat);
    check("ld_byte_data", rd, 32'h000000BE);
    check("ld_byte_lat", 32'(lat), 32'd2);
    ls_op(1'b0, 2'd1, 32'h102, 32'h0, rd, lat);
    check("ld_half_data", rd, 32'h0000DEAD);
    check("ld_half_lat", 32'(lat), 32'd3);
    ls_op(1'b0, 2'd3, 32'h100, 32'h0, rd, lat);
    check("ld_size3_data", rd, 32'hDEADBEEF);
    check("ld_size3_lat", 32'(lat), 32'd5);

    // Collisions: a fetch first makes 'if' the last grant in both arbitration modes
    fetch_op(32'h10, rd, lat);
    check("pre_coll_fetch", rd, 32'h00100513);
    collide("coll1", ls_first);
    check("coll1_order", 32'(ls_first), 32'd1);
    collide("coll2", ls_first);
    check("coll2_order", 32'(ls_first), 32'd1);
    ls_op(1'b0, 2'd0, 32'h100, 32'h0, rd, lat);
    check("coll_sep_byte", rd, 32'h000000EF);
    collide("coll3", ls_first);
    check("coll3_order", 32'(ls_first), RrEn ? 32'd0 : 32'd1);

    // rdy stall for 3 cycles in the middle of a fetch
    if_addr = 32'h10; if_req = 1'b1;
    tick;
    tick;
    check("stall_pre_mem_a", mem_a, 32'h11);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("stall_mem_a", mem_a, 32'h11);
      check("stall_mem_wr", 32'(mem_wr), 32'd0);
      check("stall_if_done", 32'(if_done), 32'd0);
    end
    rdy = 1'b1;
    begin
      int t;
      t = 0;
      while (!if_done && t < 20) begin
        tick;
        t++;
      end
      check("stall_remaining_edges", 32'(t), 32'd4);
    end
    check("stall_inst", if_inst, 32'h00100513);
    if_req = 1'b0;
    tick;

    // Reset in the middle of a store after two bytes
    ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h200; ls_wdata = 32'hCAFEF00D; ls_req = 1'b1;
    tick;
    tick;
    check("rmid_mem_a", mem_a, 32'h201);
    rst = 1'b0;
    tick;
    check("rmid_mem_wr", 32'(mem_wr), 32'd0);
    check("rmid_ls_done", 32'(ls_done), 32'd0);
    check("rmid_mem_a_clr", mem_a, 32'd0);
    rst = 1'b1;
    ls_req = 1'b0;
    repeat (3) begin
      tick;
      check("rmid_no_done", 32'(ls_done), 32'd0);
    end
    ls_op(1'b0, 2'd1, 32'h200, 32'h0, rd, lat);
    check("rmid_written_half", rd, 32'h0000F00D);
    check("rmid_idle_lat", 32'(lat), 32'd3);
    ls_op(1'b0, 2'd1, 32'h202, 32'h0, rd, lat);
    check("rmid_unwritten_half", rd, 32'h00000000);

    // Fetch across the top of the address space
    exp_a = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    if_addr = 32'hFFFFFFFE; if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("wrap_mem_a", mem_a, exp_a[k]);
    end
    tick;
    tick;
    check("wrap_done", 32'(if_done), 32'd1);
    check("wrap_inst", if_inst, 32'h44332211);
    if_req = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
